// File: rtl/sram_ctrl_pkg.sv
// Shared sizing, state encoding and fill value for the SRAM array controller.
package sram_ctrl_pkg;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 25;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    localparam logic [DATA_W-1:0] ZERO_FILL = '0;

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset sweep counter: walks every array address once and flags completion.
module sram_init_seq
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = sram_ctrl_pkg::DEPTH,
    parameter int unsigned ADDR_W = sram_ctrl_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c,
    output logic              done
);

    logic [ADDR_W-1:0] cnt_q;

    assign addr   = cnt_q;
    assign last_c = en && (cnt_q == ADDR_W'(DEPTH - 1));

    // Counter advances only while sweeping; done latches on the final address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (en && !done) begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (last_c) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_array_ctrl.sv
// Front-end for a 1R1W synchronous SRAM: zero-fill after reset, then
// valid/ready read and write channels with a stall-safe read response.
module sram_array_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = sram_ctrl_pkg::DEPTH,
    parameter int unsigned ADDR_W = sram_ctrl_pkg::ADDR_W,
    parameter int unsigned DATA_W = sram_ctrl_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,

    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,

    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,

    output logic [ADDR_W-1:0] arr_r_addr,
    output logic              arr_r_en,
    input  logic [DATA_W-1:0] arr_r_data,
    output logic [ADDR_W-1:0] arr_w_addr,
    output logic              arr_w_en,
    output logic [DATA_W-1:0] arr_w_data,
    output logic              arr_w_mask
);

    ctrl_state_e       state_q;
    ctrl_state_e       state_d;

    logic [ADDR_W-1:0] init_addr;
    logic              init_last_c;

    logic              rd_fire;
    logic              wr_fire;

    logic              resp_valid_q;
    logic              first_q;
    logic              byp_hit_q;
    logic [DATA_W-1:0] byp_data_q;
    logic [DATA_W-1:0] hold_q;

    sram_init_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (state_q == INIT),
        .addr    (init_addr),
        .last_c  (init_last_c),
        .done    (init_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request handshakes and array port muxing.
    always_comb begin
        state_d      = state_q;
        wr_req_ready = 1'b0;
        rd_req_ready = 1'b0;
        wr_fire      = 1'b0;
        rd_fire      = 1'b0;
        arr_w_en     = 1'b0;
        arr_w_addr   = init_addr;
        arr_w_data   = ZERO_FILL;
        arr_r_en     = 1'b0;
        arr_r_addr   = rd_req_addr;
        case (state_q)
            INIT: begin
                arr_w_en = 1'b1;
                if (init_last_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wr_req_ready = 1'b1;
                rd_req_ready = !resp_valid_q || rd_resp_ready;
                wr_fire      = wr_req_valid;
                rd_fire      = rd_req_valid && rd_req_ready;
                arr_w_en     = wr_fire;
                arr_w_addr   = wr_req_addr;
                arr_w_data   = wr_req_data;
                arr_r_en     = rd_fire;
            end
            default: state_d = INIT;
        endcase
    end

    assign arr_w_mask = 1'b1;

    // The macro returns pre-write data on a same-cycle collision, so a
    // colliding write is captured here and substituted on the response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            first_q      <= 1'b0;
            byp_hit_q    <= 1'b0;
            byp_data_q   <= '0;
            hold_q       <= '0;
        end else begin
            first_q <= rd_fire;
            if (rd_fire) begin
                resp_valid_q <= 1'b1;
                byp_hit_q    <= wr_fire && (wr_req_addr == rd_req_addr);
                byp_data_q   <= wr_req_data;
            end else if (rd_resp_ready) begin
                resp_valid_q <= 1'b0;
            end
            if (first_q) begin
                hold_q <= rd_resp_data;
            end
        end
    end

    assign rd_resp_valid = resp_valid_q;
    assign rd_resp_data  = !first_q  ? hold_q     :
                           byp_hit_q ? byp_data_q : arr_r_data;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: array macro model, behavioural reference, directed and random traffic.
module tb_sram_array_ctrl;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 25;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              init_done;
    logic              rd_req_valid = 1'b0;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr = '0;
    logic              rd_resp_valid;
    logic              rd_resp_ready = 1'b0;
    logic [DATA_W-1:0] rd_resp_data;
    logic              wr_req_valid = 1'b0;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr = '0;
    logic [DATA_W-1:0] wr_req_data = '0;
    logic [ADDR_W-1:0] arr_r_addr;
    logic              arr_r_en;
    logic [DATA_W-1:0] arr_r_data;
    logic [ADDR_W-1:0] arr_w_addr;
    logic              arr_w_en;
    logic [DATA_W-1:0] arr_w_data;
    logic              arr_w_mask;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sram_array_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .init_done     (init_done),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_resp_data  (rd_resp_data),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .arr_r_addr    (arr_r_addr),
        .arr_r_en      (arr_r_en),
        .arr_r_data    (arr_r_data),
        .arr_w_addr    (arr_w_addr),
        .arr_w_en      (arr_w_en),
        .arr_w_data    (arr_w_data),
        .arr_w_mask    (arr_w_mask)
    );

    // Array macro: 1-cycle read latency, old data on collision, garbage when idle.
    logic [DATA_W-1:0] arr_mem [DEPTH];
    logic              scramble = 1'b1;

    always @(posedge clock) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) arr_mem[i] <= DATA_W'($urandom);
        end else if (arr_w_en && arr_w_mask) begin
            arr_mem[arr_w_addr] <= arr_w_data;
        end
        arr_r_data <= arr_r_en ? arr_mem[arr_r_addr] : DATA_W'($urandom);
    end

    // Reference: logical memory contents plus the single expected response.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_cnt;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_done;
    logic              m_rd_ready;

    assign m_done     = reset_n && (m_cnt >= DEPTH);
    assign m_rd_ready = m_done && (!m_valid || rd_resp_ready);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (!m_done) begin
            m_mem[ADDR_W'(m_cnt)] <= '0;
            m_cnt <= m_cnt + 1;
        end else begin
            if (wr_req_valid) m_mem[wr_req_addr] <= wr_req_data;
            if (rd_req_valid && m_rd_ready) begin
                m_valid <= 1'b1;
                m_data  <= (wr_req_valid && wr_req_addr == rd_req_addr) ? wr_req_data
                                                                         : m_mem[rd_req_addr];
            end else if (rd_resp_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference, sampled mid-cycle.
    always @(negedge clock) begin
        chk("init_done", 32'(init_done), 32'(m_done));
        chk("wr_req_ready", 32'(wr_req_ready), 32'(m_done));
        chk("rd_req_ready", 32'(rd_req_ready), 32'(m_rd_ready));
        chk("rd_resp_valid", 32'(rd_resp_valid), 32'(m_valid));
        chk("arr_w_mask", 32'(arr_w_mask), 32'd1);
        if (m_valid) chk("rd_resp_data", 32'(rd_resp_data), 32'(m_data));
        if (reset_n && !m_done) begin
            chk("sweep_w_en", 32'(arr_w_en), 32'd1);
            chk("sweep_w_data", 32'(arr_w_data), 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_init(input string nm);
        int n = 0;
        while (!init_done && n < 100) begin
            cyc();
            n++;
        end
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        chk(nm, 32'(n), 32'd32);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_req_valid = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        cyc();
        wr_req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string nm);
        rd_req_valid  = 1'b1;
        rd_req_addr   = a;
        rd_resp_ready = 1'b1;
        cyc();
        rd_req_valid = 1'b0;
        chk({nm, "_valid"}, 32'(rd_resp_valid), 32'd1);
        chk(nm, 32'(rd_resp_data), 32'(exp));
        cyc();
    endtask

    initial begin
        repeat (2) cyc();
        scramble = 1'b0;
        // Requests raised during the sweep must be ignored.
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        wr_req_addr  = 5'd17;
        wr_req_data  = 25'h1FFFFFF;
        reset_n      = 1'b1;
        wait_init("init_latency");

        do_read(5'd0, 25'h0, "zero_a0");
        do_read(5'd17, 25'h0, "zero_a17");
        do_read(5'd31, 25'h0, "zero_a31");

        do_write(5'd5, 25'h1ABCDEF);
        do_read(5'd5, 25'h1ABCDEF, "wr_then_rd");

        wr_req_valid = 1'b1;
        wr_req_addr  = 5'd9;
        wr_req_data  = 25'h0000123;
        do_read(5'd9, 25'h0000123, "same_cycle");

        // Stalled response must hold while the entry is overwritten.
        do_write(5'd3, 25'h0155555);
        rd_req_valid  = 1'b1;
        rd_req_addr   = 5'd3;
        rd_resp_ready = 1'b0;
        cyc();
        rd_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("stall_data", 32'(rd_resp_data), 32'h0155555);
            chk("stall_rdy", 32'(rd_req_ready), 32'd0);
            if (k == 1) begin
                wr_req_valid = 1'b1;
                wr_req_addr  = 5'd3;
                wr_req_data  = 25'h0AAAAAA;
            end
            cyc();
            wr_req_valid = 1'b0;
        end
        rd_resp_ready = 1'b1;
        chk("stall_final", 32'(rd_resp_data), 32'h0155555);
        cyc();
        chk("stall_release", 32'(rd_resp_valid), 32'd0);
        do_read(5'd3, 25'h0AAAAAA, "after_stall");

        // Streaming reads, one per cycle.
        for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), DATA_W'(i * 32'h11111));
        rd_resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = ADDR_W'(i);
            cyc();
            chk("stream_valid", 32'(rd_resp_valid), 32'd1);
            chk("stream_data", 32'(rd_resp_data), i * 32'h11111);
        end
        rd_req_valid = 1'b0;
        cyc();

        // Randomised traffic, collisions encouraged by a narrow address window.
        for (int c = 0; c < 3000; c++) begin
            logic narrow;
            narrow        = $urandom_range(0, 1) == 1;
            rd_req_valid  = $urandom_range(0, 1) == 1;
            rd_req_addr   = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
            rd_resp_ready = $urandom_range(0, 3) != 0;
            wr_req_valid  = $urandom_range(0, 2) == 0;
            wr_req_addr   = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
            wr_req_data   = DATA_W'($urandom);
            cyc();
        end
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        rd_resp_ready = 1'b1;
        cyc();

        // Reset during a pending response, then again mid-sweep.
        rd_req_valid  = 1'b1;
        rd_req_addr   = 5'd5;
        rd_resp_ready = 1'b0;
        cyc();
        rd_req_valid = 1'b0;
        chk("pre_reset_valid", 32'(rd_resp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_valid", 32'(rd_resp_valid), 32'd0);
        chk("reset_rd_rdy", 32'(rd_req_ready), 32'd0);
        cyc();
        reset_n = 1'b1;
        repeat (10) cyc();
        chk("mid_sweep_done", 32'(init_done), 32'd0);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        wait_init("reinit_latency");
        do_read(5'd5, 25'h0, "reinit_zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_array_ctrl.md
Name: sram_array_ctrl

Overview:
- Controller in front of a 32-entry x 25-bit 1R1W synchronous SRAM macro with 1-cycle read latency and a 1-bit write mask.
- After reset it zero-fills the array. It then serves independent valid/ready read and write request channels.
- It returns read data through a backpressurable response channel and holds that data stable while stalled.
- It sits between pipeline requesters (for example predictor/table update logic) and the raw array macro.

Parameters:
- DEPTH, 32, number of array entries.
- ADDR_W, 5, address width; must equal log2(DEPTH).
- DATA_W, 25, entry width.

Ports:
- clock  in  1  single clock for the controller and the array.
- reset_n  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the zero-fill sweep has completed.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted.
- rd_req_addr  in  ADDR_W  read address.
- rd_resp_valid  out  1  read data valid.
- rd_resp_ready  in  1  consumer accepts read data.
- rd_resp_data  out  DATA_W  read data.
- wr_req_valid  in  1  write request valid.
- wr_req_ready  out  1  write request accepted.
- wr_req_addr  in  ADDR_W  write address.
- wr_req_data  in  DATA_W  write data.
- arr_r_addr  out  ADDR_W  array read address.
- arr_r_en  out  1  array read enable.
- arr_r_data  in  DATA_W  array read data; valid the cycle after arr_r_en and garbage otherwise.
- arr_w_addr  out  ADDR_W  array write address.
- arr_w_en  out  1  array write enable.
- arr_w_data  out  DATA_W  array write data.
- arr_w_mask  out  1  array write mask; driven constant 1.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - FSM = INIT, init counter = 0;
  - init_done = 0, rd_resp_valid = 0, rd_req_ready = 0, wr_req_ready = 0, arr_r_en = 0;
  - hold register cleared to 0.
- A pending response is discarded on reset; reset mid-sweep restarts the sweep from address 0.
- INIT state:
  - Each cycle: arr_w_en = 1, arr_w_addr = counter, arr_w_data = 0, counter++.
  - The cycle that writes DEPTH-1 transitions to RUN; the sweep takes exactly DEPTH cycles.
  - Both request readies stay 0 throughout; requester valids are ignored.
- RUN state (terminal until the next reset):
  - init_done = 1 from the first RUN cycle.
  - wr_req_ready = 1 always. Write fire = wr_req_valid & wr_req_ready.
  - On write fire, drive arr_w_en / arr_w_addr / arr_w_data combinationally in the same cycle; no write queue.
  - rd_req_ready = !rd_resp_valid | rd_resp_ready, i.e. at most one outstanding read.
  - Read fire in cycle T: arr_r_en = 1, arr_r_addr = rd_req_addr in T.
- Read response:
  - rd_resp_valid rises in T+1 and stays high until rd_resp_ready is sampled high.
  - First response cycle (T+1): rd_resp_data = arr_r_data, and it is captured into the hold register at the end of that cycle.
  - Later stalled cycles: rd_resp_data = hold register, so data stays stable despite array garbage or later writes.
  - Back-to-back reads: read fire and response handshake in the same cycle give 1 read/cycle throughput; the next response replaces the current one in T+2.
- Ordering:
  - A read returns the array contents including every write fired in the same cycle or earlier than the read fire.
  - A same-cycle write to the read address returns the new data.
  - Writes fired after the read fire never alter a pending response.
- Simultaneous read and write fire to any addresses is always legal.
- Address rules: addresses are used unmodified; no range check is needed because DEPTH = 2^ADDR_W.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - DEPTH / ADDR_W / DATA_W defaults;
  - FSM state enum (INIT, RUN) as a 1-bit type;
  - constant ZERO_FILL = 0.
- One natural sub-module: sram_init_seq (counter plus done flag, driving the write port during INIT). The muxing onto the array write port stays in the top level.

Test Plan:
- Reset, then idle: init_done rises exactly 32 cycles after reset_n deasserts; the array then reads 0 at addresses 0, 17 and 31. Readies stay low throughout INIT.
- Write 0x1ABCDEF to address 5, then read address 5 with rd_resp_ready=1: rd_resp_valid appears 1 cycle after the read fire, with data 0x1ABCDEF.
- Same-cycle write 0x0000123 and read, both to address 9: the response is 0x0000123.
- Read address 3 (holding 0x0155555) with rd_resp_ready=0 for 4 cycles, while writing 0x0AAAAAA to address 3 during the stall:
  - data stays 0x0155555 on every stalled cycle;
  - rd_req_ready stays 0 until the handshake completes.
- Streaming reads of addresses 0..7 with rd_resp_ready=1: 8 responses on 8 consecutive cycles, in order, with correct data.
- Assert reset_n low mid-sweep (cycle 10) and mid-response: rd_resp_valid drops immediately; the sweep restarts and takes a full 32 cycles again.
